// File: rtl/event_monitor_pkg.sv
// Shared types, parameter limits and helpers for the event monitor.
package event_monitor_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    typedef enum logic {
        ARM_FILL  = 1'b0,
        ARM_ARMED = 1'b1
    } arm_state_e;

    localparam int NUM_CH_MIN      = 1;
    localparam int NUM_CH_MAX      = 32;
    localparam int CNT_W_MIN       = 2;
    localparam int CNT_W_MAX       = 32;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILL_CNT_W      = 3;

    // Largest value a CNT_W-bit counter can hold before it saturates.
    function automatic logic [31:0] cnt_max(input int w);
        if (w >= 32)
            return 32'hFFFF_FFFF;
        else
            return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/event_monitor_chan.sv
// One monitor channel: synchroniser, edge detect, qualifier, saturating counter and sticky flags.
module event_chan
    import event_monitor_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             armed,
    input  logic             sig_in,
    input  logic             qual_en,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             evt_hit,
    output logic             evt_pulse,
    output logic             pending,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   evt_pulse_reg;
    logic                   pending_reg, pending_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   overflow_reg, overflow_next;

    logic       sync_s;
    logic       rise, fall, edge_match;
    edge_mode_e mode_e;

    assign sync_s = sync_reg[SYNC_STAGES-1];
    assign rise   = sync_s & ~prev_reg;
    assign fall   = ~sync_s & prev_reg;
    assign mode_e = edge_mode_e'(mode);

    always_comb begin
        edge_match = 1'b0;
        case (mode_e)
            MODE_RISE: edge_match = rise;
            MODE_FALL: edge_match = fall;
            MODE_BOTH: edge_match = rise | fall;
            default:   edge_match = 1'b0;
        endcase
    end

    assign evt_hit = armed & qual_en & edge_match;

    // A qualified event in the same cycle as a clear wins: the channel restarts at one.
    always_comb begin
        pending_next  = pending_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (clr) begin
            pending_next  = evt_hit;
            count_next    = evt_hit ? CNT_W'(1) : '0;
            overflow_next = 1'b0;
        end else if (evt_hit) begin
            pending_next = 1'b1;
            if (count_reg == CNT_MAX)
                overflow_next = 1'b1;
            else
                count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg      <= '0;
            prev_reg      <= 1'b0;
            evt_pulse_reg <= 1'b0;
            pending_reg   <= 1'b0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            prev_reg      <= sync_s;
            evt_pulse_reg <= evt_hit;
            pending_reg   <= pending_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign evt_pulse = evt_pulse_reg;
    assign pending   = pending_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;

endmodule

// File: rtl/event_monitor.sv
// Multi-channel edge/event monitor: shared arm FSM, per-channel monitors and a registered any-event flag.
module event_monitor
    import event_monitor_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       sig_in,
    input  logic [NUM_CH-1:0]       qual_en,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       evt_pulse,
    output logic [NUM_CH-1:0]       pending,
    output logic [CNT_W*NUM_CH-1:0] count,
    output logic [NUM_CH-1:0]       overflow,
    output logic                    any_evt,
    output logic                    armed
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
        CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX ||
        SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_param_err
        $error("event_monitor: parameter out of range");
    end

    arm_state_e            state_reg, state_next;
    logic [FILL_CNT_W-1:0] fill_cnt_reg, fill_cnt_next;
    logic                  any_evt_reg;
    logic [NUM_CH-1:0]     evt_hit;

    // Hold detection off until the synchroniser and previous-value flop carry real input levels.
    always_comb begin
        state_next    = state_reg;
        fill_cnt_next = fill_cnt_reg;
        case (state_reg)
            ARM_FILL: begin
                if (fill_cnt_reg == FILL_CNT_W'(SYNC_STAGES))
                    state_next = ARM_ARMED;
                else
                    fill_cnt_next = fill_cnt_reg + FILL_CNT_W'(1);
            end
            default: state_next = ARM_ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ARM_FILL;
            fill_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= fill_cnt_next;
        end
    end

    assign armed = (state_reg == ARM_ARMED);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        event_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .armed     (armed),
            .sig_in    (sig_in[gi]),
            .qual_en   (qual_en[gi]),
            .mode      (mode[2*gi +: 2]),
            .clr       (clr[gi]),
            .evt_hit   (evt_hit[gi]),
            .evt_pulse (evt_pulse[gi]),
            .pending   (pending[gi]),
            .count     (count[CNT_W*gi +: CNT_W]),
            .overflow  (overflow[gi])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            any_evt_reg <= 1'b0;
        else
            any_evt_reg <= |evt_hit;
    end

    assign any_evt = any_evt_reg;

endmodule

// File: tb/tb_event_monitor.sv
// Self-checking bench for event_monitor: pulse scoreboard plus direct state checks.
module tb_event_monitor;
    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 2;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       sig_in;
    logic [NUM_CH-1:0]       qual_en;
    logic [2*NUM_CH-1:0]     mode;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH-1:0]       evt_pulse;
    logic [NUM_CH-1:0]       pending;
    logic [CNT_W*NUM_CH-1:0] count;
    logic [NUM_CH-1:0]       overflow;
    logic                    any_evt;
    logic                    armed;

    typedef struct {
        int ch;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    event_monitor #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .qual_en   (qual_en),
        .mode      (mode),
        .clr       (clr),
        .evt_pulse (evt_pulse),
        .pending   (pending),
        .count     (count),
        .overflow  (overflow),
        .any_evt   (any_evt),
        .armed     (armed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int get_cnt(input int i);
        logic [CNT_W*NUM_CH-1:0] sh;
        sh = count >> (CNT_W * i);
        return int'(sh[CNT_W-1:0]);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode[2*ch +: 2] = m;
    endtask

    // Rising then falling level on one channel; a qualified rise is expected LAT edges later.
    task automatic pulse_rise(input int ch, input bit expect_evt);
        sig_in[ch] = 1'b1;
        if (expect_evt) sb_q.push_back('{ch: ch, due: cyc + LAT});
        wait_clks(4);
        sig_in[ch] = 1'b0;
        wait_clks(4);
    endtask

    // Scoreboard side: every observed pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && evt_pulse != '0) begin
            check_val("any_evt", 32'(any_evt), 32'd1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (evt_pulse[i]) begin
                    if (sb_q.size() == 0) begin
                        check_val("evt_unexpected_ch", i, NUM_CH);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        $display("evt ch=%0d cyc=%0d exp_ch=%0d exp_cyc=%0d", i, cyc, e.ch, e.due);
                        check_val("evt_ch", i, e.ch);
                        check_val("evt_cyc", cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        sig_in  = 4'b0001;
        qual_en = '1;
        mode    = '0;
        clr     = '0;
        set_mode(0, 2'b01);
        wait_clks(3);
        check_val("rst_armed", 32'(armed), 0);
        check_val("rst_count", 32'(count), 0);
        check_val("rst_pending", 32'(pending), 0);

        // Priming: level held through reset must not produce an event.
        reset = 1'b0;
        wait_clks(2);
        check_val("armed_early", 32'(armed), 0);
        wait_clks(1);
        check_val("armed_rise", 32'(armed), 1);
        wait_clks(4);
        check_val("prime_pending0", 32'(pending[0]), 0);
        check_val("prime_count0", get_cnt(0), 0);
        sig_in[0] = 1'b0;
        wait_clks(4);

        // Qualifier on channel 1.
        set_mode(1, 2'b01);
        qual_en[1] = 1'b1; pulse_rise(1, 1);
        qual_en[1] = 1'b0; pulse_rise(1, 0);
        qual_en[1] = 1'b1; pulse_rise(1, 1);
        check_val("qual_count1", get_cnt(1), 2);
        check_val("qual_pending1", 32'(pending[1]), 1);

        // Modes: ch2 BOTH, ch3 FALL, then ch2 OFF.
        set_mode(2, 2'b11);
        set_mode(3, 2'b10);
        sig_in[3:2] = 2'b11;
        sb_q.push_back('{ch: 2, due: cyc + LAT});
        wait_clks(4);
        sig_in[3:2] = 2'b00;
        sb_q.push_back('{ch: 2, due: cyc + LAT});
        sb_q.push_back('{ch: 3, due: cyc + LAT});
        wait_clks(4);
        check_val("both_count2", get_cnt(2), 2);
        check_val("fall_count3", get_cnt(3), 1);
        set_mode(2, 2'b00);
        sig_in[3:2] = 2'b11;
        wait_clks(4);
        sig_in[3:2] = 2'b00;
        sb_q.push_back('{ch: 3, due: cyc + LAT});
        wait_clks(4);
        check_val("off_count2", get_cnt(2), 2);
        check_val("fall_count3b", get_cnt(3), 2);

        // Saturation on channel 0.
        for (int k = 0; k < 5; k++) pulse_rise(0, 1);
        check_val("sat_count0", get_cnt(0), 3);
        check_val("sat_overflow0", 32'(overflow[0]), 1);
        check_val("sat_pending0", 32'(pending[0]), 1);
        clr[0] = 1'b1;
        wait_clks(1);
        clr[0] = 1'b0;
        check_val("clr_count0", get_cnt(0), 0);
        check_val("clr_overflow0", 32'(overflow[0]), 0);
        check_val("clr_pending0", 32'(pending[0]), 0);
        check_val("clr_count1_kept", get_cnt(1), 2);

        // Clear colliding with a qualified event.
        for (int k = 0; k < 4; k++) pulse_rise(0, 1);
        check_val("sat2_overflow0", 32'(overflow[0]), 1);
        sig_in[0] = 1'b1;
        sb_q.push_back('{ch: 0, due: cyc + LAT});
        wait_clks(2);
        clr[0] = 1'b1;
        wait_clks(1);
        clr[0] = 1'b0;
        check_val("coll_count0", get_cnt(0), 1);
        check_val("coll_pending0", 32'(pending[0]), 1);
        check_val("coll_overflow0", 32'(overflow[0]), 0);
        wait_clks(2);
        sig_in[0] = 1'b0;
        wait_clks(4);

        // Asynchronous reset mid-run.
        pulse_rise(0, 1);
        check_val("pre_rst_count0", get_cnt(0), 2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("arst_count", 32'(count), 0);
        check_val("arst_pending", 32'(pending), 0);
        check_val("arst_overflow", 32'(overflow), 0);
        check_val("arst_armed", 32'(armed), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sig_in[0] = 1'b1;
        wait_clks(2);
        check_val("rearm_early", 32'(armed), 0);
        wait_clks(1);
        check_val("rearm", 32'(armed), 1);
        wait_clks(3);
        check_val("rearm_count0", get_cnt(0), 0);
        sig_in[0] = 1'b0;
        wait_clks(4);
        pulse_rise(0, 1);
        check_val("post_count0", get_cnt(0), 1);

        wait_clks(4);
        check_val("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/event_monitor.md
# event_monitor

Multi-channel, parametrised edge/event monitor for the verification and debug fabric. Each channel synchronises an asynchronous input, detects rising and/or falling edges per a run-time mode, and qualifies each edge with an enable. The qualification is the synthesizable equivalent of a `@(posedge x iff en)` event control. Qualified events produce a one-cycle pulse, a sticky pending flag and a saturating per-channel count.

## Interface
- NUM_CH, 4, number of independent channels (1..32)
- CNT_W, 8, width of each event counter (2..32)
- SYNC_STAGES, 2, synchroniser depth per input (2..4)

- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- sig_in  input  NUM_CH  asynchronous monitored signals, bit i = channel i
- qual_en  input  NUM_CH  per-channel qualifier; an edge counts only if set
- mode  input  2*NUM_CH  per-channel edge_mode_e, bits [2i+1:2i]: 00 OFF, 01 RISE, 10 FALL, 11 BOTH
- clr  input  NUM_CH  per-channel synchronous clear of pending, count and overflow
- evt_pulse  output  NUM_CH  one-cycle pulse per qualified event
- pending  output  NUM_CH  sticky event flag
- count  output  CNT_W*NUM_CH  saturating event count, channel i at [CNT_W*i +: CNT_W]
- overflow  output  NUM_CH  sticky: an event arrived while count was at max
- any_evt  output  1  OR of evt_pulse
- armed  output  1  detection enabled (pipeline primed after reset)

## Operation
- Per channel: SYNC_STAGES flop chain → `s`; register `p` holds the previous `s`.
  - rise = `s & ~p`; fall = `~s & p`.
- A qualified event requires all of the following:
  - `armed`;
  - the edge matches `mode`;
  - `qual_en` is high in the detection cycle.
- Arm FSM (shared by all channels), states FILL → ARMED:
  - Reset enters FILL with the fill counter at 0.
  - FILL counts SYNC_STAGES+1 clocks, then moves to ARMED.
  - ARMED holds until reset.
  - Purpose: a level already present on `sig_in` at reset release is not reported as an edge.
- On a qualified event:
  - `evt_pulse` = 1 for one cycle and `pending` set.
  - If count < 2^CNT_W−1, count increments; otherwise count holds and `overflow` is set.
- `clr[i]`:
  - Without an event in the same cycle: pending ← 0, count ← 0, overflow ← 0.
  - With a qualified event in the same cycle: pending ← 1, count ← 1, overflow ← 0 (the event wins over clear).
- `mode` OFF or `qual_en` low: edges are silently dropped. Dropped edges are not remembered and do not produce a late pulse.
- Changing `mode` or `qual_en` takes effect on the next detection cycle. No internal state is reset by the change.
- Channels are fully independent; simultaneous events on several channels are all recorded.

## Timing
- Reset values:
  - All sync flops, `p`, evt_pulse, pending, count, overflow, any_evt, armed = 0.
  - FSM state = FILL.
- Latency: a level change sampled at clock edge E0 appears on `evt_pulse`, `pending` and `count` after edge E(SYNC_STAGES). With SYNC_STAGES=2 that is 2 clocks.
- `any_evt` is registered together with evt_pulse and has the same latency.
- `armed` rises SYNC_STAGES+1 clocks after reset deassertion.
- `clr` acts at the next clock edge, with zero latency to the outputs after that edge.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous) and the FSM returns to FILL.
- Pulse width is exactly one clk.
- Edges closer than one clk after synchronisation are not guaranteed to be separated. A glitch shorter than a clk period may be missed.

## Structure
- Package `event_monitor_pkg`:
  - `edge_mode_e` enum (OFF, RISE, FALL, BOTH);
  - parameter range checks as localparams;
  - `cnt_max(CNT_W)` helper function.
- Sub-module `event_chan`:
  - one channel: synchroniser, edge detect, qualifier, counter, sticky flags;
  - takes `armed` as an input;
  - instantiated NUM_CH times in a generate loop.
- Top level holds the arm FSM and the any_evt OR-reduce.

## Test plan
- Reset priming: hold sig_in[0]=1 through reset, mode=RISE, qual_en=1, release → no evt_pulse; armed=1 after 3 clocks (SYNC_STAGES=2).
- Qualifier: ch1 mode=RISE; toggle sig_in[1] 0→1 three times with qual_en=1, 0, 1 respectively → count[1]=2, two pulses, each 2 clocks after sampling.
- Modes: ch2 BOTH, ch3 FALL; apply one full pulse to both → count[2]=2, count[3]=1; set ch2 OFF, pulse again → count[2] unchanged.
- Saturation: CNT_W=2, ch0 RISE, 5 qualified rises → count=3, overflow=1, pending=1; then clr → all 0.
- Clear collision: assert clr[0] in the cycle a qualified event lands → count[0]=1, pending[0]=1, overflow[0]=0.
- Reset mid-run: with count[0]=2, assert reset asynchronously between edges → outputs 0 immediately, armed=0; edges are ignored until armed re-rises.
